// File: rtl/ascon_sbox_loader.sv
// ascon_sbox_loader
//
// Register-bus initiator that programs the 32-entry, 5-bit S-box table of the
// ASCON permutation core. A start pulse in idle captures the 160-bit table.
// The block then writes entries 0..31 back-to-back on the bus.
//
// Optional readback: define ASCON_SBOX_READBACK_EN. With it defined, each entry
// is also read back and compared after the write pass.
//
// Parameters:
//   BASE_ADDR    bus address of entry 0
//   ADDR_STRIDE  byte increment per entry (address wraps modulo 2^32)
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   start_i         load request, sampled only in idle
//   table_i         table to load, entry i = table_i[5*i +: 5]
//   reg_req_o       bus request (valid/addr/write/wdata/wstrb)
//   reg_rsp_i       bus response (ready/rdata/error)
//   busy_o          sequence in progress
//   done_o          one-cycle pulse at the end of a sequence (pass or fail)
//   error_o         sticky failure flag, cleared by the next accepted start
//   err_idx_o       index of the failing entry, valid while error_o is set

package ascon_sbox_loader_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

module ascon_sbox_loader
    import ascon_sbox_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] ADDR_STRIDE = 32'd4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic [159:0] table_i,
    output reg_req_t     reg_req_o,
    input  reg_rsp_t     reg_rsp_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         error_o,
    output logic [4:0]   err_idx_o
);

`ifdef ASCON_SBOX_READBACK_EN
    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;
`else
    typedef enum logic [0:0] {StIdle, StWrite} state_e;
`endif

    state_e       state_q, state_d;
    logic [4:0]   idx_q, idx_d;
    logic [159:0] table_q, table_d;
    logic         done_q, done_d;
    logic         error_q, error_d;
    logic [4:0]   err_idx_q, err_idx_d;

    logic [4:0]   entries [32];
    logic [4:0]   entry;
    logic [31:0]  req_addr;
    logic         last;

    for (genvar g = 0; g < 32; g++) begin : g_entries
        assign entries[g] = table_q[5*g +: 5];
    end

    assign entry    = entries[idx_q];
    assign req_addr = BASE_ADDR + ADDR_STRIDE * {27'b0, idx_q};
    assign last     = (idx_q == 5'd31);

`ifndef ASCON_SBOX_READBACK_EN
    // Read data only matters for the readback compare.
    logic [31:0] unused_rdata;
    assign unused_rdata = reg_rsp_i.rdata;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        table_d   = table_q;
        done_d    = 1'b0;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        reg_req_o = '0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    table_d   = table_i;
                    idx_d     = '0;
                    error_d   = 1'b0;
                    err_idx_d = '0;
                    state_d   = StWrite;
                end
            end

            StWrite: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.write = 1'b1;
                reg_req_o.addr  = req_addr;
                reg_req_o.wdata = {27'b0, entry};
                reg_req_o.wstrb = 4'b0001;
                if (reg_rsp_i.ready) begin
                    if (reg_rsp_i.error) begin
                        state_d   = StIdle;
                        done_d    = 1'b1;
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                    end else if (last) begin
`ifdef ASCON_SBOX_READBACK_EN
                        state_d = StRead;
                        idx_d   = '0;
`else
                        state_d = StIdle;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end

`ifdef ASCON_SBOX_READBACK_EN
            StRead: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.addr  = req_addr;
                if (reg_rsp_i.ready) begin
                    // Only the low five bits carry the entry; upper bits are don't-care.
                    if (reg_rsp_i.error || (reg_rsp_i.rdata[4:0] != entry)) begin
                        state_d   = StIdle;
                        done_d    = 1'b1;
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                    end else if (last) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
`endif

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            table_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            table_q   <= table_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;
    assign error_o   = error_q;
    assign err_idx_o = err_idx_q;

endmodule

// File: tb/tb_ascon_sbox_loader.sv
// Self-checking bench for ascon_sbox_loader. A randomized responder drives the
// bus. A transaction-level model predicts each cycle's request, busy/done and
// the final error state. Works with or without ASCON_SBOX_READBACK_EN.
module tb_ascon_sbox_loader;
    import ascon_sbox_loader_pkg::*;

    localparam logic [31:0] Base = 32'h0000_0100;
`ifdef ASCON_SBOX_READBACK_EN
    localparam int NTx = 64;
    localparam bit Readback = 1'b1;
`else
    localparam int NTx = 32;
    localparam bit Readback = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [159:0] tbl_in;
    reg_req_t     req;
    reg_rsp_t     rsp;
    logic         busy, done, error;
    logic [4:0]   err_idx;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ascon_sbox_loader #(
        .BASE_ADDR   (Base),
        .ADDR_STRIDE (32'd4)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .table_i   (tbl_in),
        .reg_req_o (req),
        .reg_rsp_i (rsp),
        .busy_o    (busy),
        .done_o    (done),
        .error_o   (error),
        .err_idx_o (err_idx)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ref_entry(input logic [159:0] t, input int i);
        return t[5*i +: 5];
    endfunction

    function automatic logic [159:0] rand_table();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t;
    endfunction

    task automatic drive_start(input logic [159:0] t);
        start  = 1'b1;
        tbl_in = t;
    endtask

    // Expects start already driven at a negedge. Transaction k: entry k%32,
    // write for k<32, read afterwards. err_k / corrupt_k pick the failing one.
    task automatic run_seq(input logic [159:0] t, input int err_k, input int corrupt_k,
                           input int stall_pct, input int stall_k, input int stall_len,
                           input bit chain, input logic [159:0] next_t);
        int k       = 0;
        int stalled = 0;
        bit fin     = 1'b0;
        bit exp_err = 1'b0;
        int exp_idx = 0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!fin) begin
                int i;
                bit wr;
                bit rdy;
                i  = k % 32;
                wr = (k < 32);
                check_val("busy", busy, 1);
                check_val("done_early", done, 0);
                check_val("error_running", error, 0);
                check_val("valid", req.valid, 1);
                check_val("write", req.write, wr);
                check_val("addr", req.addr, Base + 32'(4 * i));
                check_val("wdata", req.wdata, wr ? 32'(ref_entry(t, i)) : 32'd0);
                check_val("wstrb", req.wstrb, wr ? 4'b0001 : 4'b0000);
                if (k == stall_k && stalled < stall_len) begin
                    rdy = 1'b0;
                    stalled++;
                end else begin
                    rdy = ($urandom_range(99) >= stall_pct);
                end
                rsp.ready = rdy;
                rsp.error = rdy ? (k == err_k) : 1'($urandom);
                rsp.rdata = $urandom;
                if (rdy && !wr)
                    rsp.rdata[4:0] = ref_entry(t, i) ^ ((k == corrupt_k) ? 5'd1 : 5'd0);
                if (rdy) begin
                    if (k == err_k || (!wr && k == corrupt_k)) begin
                        fin     = 1'b1;
                        exp_err = 1'b1;
                        exp_idx = i;
                    end else if (k == NTx - 1) begin
                        fin = 1'b1;
                    end else begin
                        k++;
                    end
                end
                start  = 1'($urandom);
                tbl_in = rand_table();
                @(posedge clk);
                @(negedge clk);
            end else begin
                check_val("end_valid", req.valid, 0);
                check_val("end_busy", busy, 0);
                check_val("end_done", done, 1);
                check_val("end_error", error, exp_err);
                if (exp_err) check_val("err_idx", err_idx, exp_idx);
                rsp = '0;
                if (chain) begin
                    start  = 1'b1;
                    tbl_in = next_t;
                end else begin
                    start = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                    check_val("after_done", done, 0);
                    check_val("after_valid", req.valid, 0);
                    check_val("after_error", error, exp_err);
                end
                return;
            end
        end
        check_val("timeout", 0, 1);
        rsp   = '0;
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_valid"}, req.valid, 0);
        check_val({tag, "_addr"}, req.addr, 0);
        check_val({tag, "_wdata"}, req.wdata, 0);
        check_val({tag, "_wstrb"}, req.wstrb, 0);
        check_val({tag, "_write"}, req.write, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_error"}, error, 0);
        check_val({tag, "_err_idx"}, err_idx, 0);
    endtask

    initial begin
        logic [159:0] sbox;
        logic [159:0] tnext;
        logic [4:0]   sb [32];
        sb = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
               5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
               5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
               5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
        for (int i = 0; i < 32; i++) sbox[5*i +: 5] = sb[i];

        rst_n  = 1'b0;
        start  = 1'b0;
        tbl_in = '0;
        rsp    = '0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");

        // Plain load, ready always high.
        drive_start(sbox);
        run_seq(sbox, -1, -1, 0, -1, 0, 1'b0, '0);
        // Three stall cycles on entry 5.
        drive_start(sbox);
        run_seq(sbox, -1, -1, 0, 5, 3, 1'b0, '0);
        // Bus error on the write of entry 9.
        drive_start(sbox);
        run_seq(sbox, 9, -1, 0, -1, 0, 1'b0, '0);
        // Failure, then restart in the done cycle (error must clear on it).
        tnext = rand_table();
        drive_start(sbox);
        if (Readback) run_seq(sbox, -1, 32 + 20, 0, -1, 0, 1'b1, tnext);
        else          run_seq(sbox, 20, -1, 0, -1, 0, 1'b1, tnext);
        run_seq(tnext, -1, -1, 30, -1, 0, 1'b0, '0);

        // Reset in cycle 10 of a load, then a fresh load from entry 0.
        drive_start(sbox);
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        rsp.ready = 1'b1;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_val("pre_reset_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        rsp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");
        drive_start(sbox);
        run_seq(sbox, -1, -1, 20, -1, 0, 1'b0, '0);

        // Random tables, random stalls and random failure points.
        for (int r = 0; r < 10; r++) begin
            logic [159:0] t;
            int ek;
            int ck;
            t  = rand_table();
            ek = ($urandom_range(2) == 0) ? int'($urandom_range(NTx - 1)) : -1;
            ck = (Readback && $urandom_range(1) == 1) ? 32 + int'($urandom_range(31)) : -1;
            drive_start(t);
            run_seq(t, ek, ck, 25, -1, 0, 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
